nco_sweep_ctrl: RTL and testbench

//  Sequences the NCO phase-increment input to produce frequency sweeps (chirps).

---
 rtl/nco_ctrl_pkg.sv | 28 ++
 rtl/nco_dwell_timer.sv | 34 +++
 rtl/nco_sweep_ctrl.sv | 149 ++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nco_ctrl_pkg.sv
// Shared types and defaults for the NCO sweep controller.
package nco_ctrl_pkg;

   localparam int PINC_W_DEF  = 32;
   localparam int DWELL_W_DEF = 16;

   typedef enum logic [1:0] {
      MODE_SINGLE = 2'd0,
      MODE_CONT   = 2'd1,
      MODE_TRI    = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // The reserved encoding behaves exactly like a single sweep.
   function automatic mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'd1:    return MODE_CONT;
         2'd2:    return MODE_TRI;
         default: return MODE_SINGLE;
      endcase
   endfunction

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter; expire is high during the last cycle of a dwell.
module nco_dwell_timer #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_val,
   output logic               expire
);

   logic [DWELL_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (load)
         cnt_d = (load_val == '0) ? DWELL_W'(1) : load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - DWELL_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expire = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the NCO phase increment from start to stop
// in single, sawtooth or triangle fashion, holding each point for a dwell.
module nco_sweep_ctrl
   import nco_ctrl_pkg::*;
#(
   parameter int PINC_W  = PINC_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         cfg_mode,
   input  logic [PINC_W-1:0]  cfg_start,
   input  logic [PINC_W-1:0]  cfg_stop,
   input  logic [PINC_W-1:0]  cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   output logic               nco_in_valid,
   output logic [PINC_W-1:0]  nco_in_data,
   output logic               busy,
   output logic               done
);

   state_e              state_q, state_d;
   mode_e               mode_q, mode_d;
   logic [PINC_W-1:0]   start_q, start_d, stop_q, stop_d, step_q, step_d, cur_q, cur_d;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   logic                up_q, up_d, fwd_q, fwd_d;

   logic                tmr_load, tmr_clr, tmr_expire;
   logic [DWELL_W-1:0]  tmr_val;
   logic                at_end, next_fwd, step_up;
   logic [PINC_W-1:0]   tgt_cur, tgt_next, stepped;
   logic [PINC_W:0]     sum_w, diff_w;

   nco_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
      .clk      (clk),
      .rst      (rst),
      .clr      (tmr_clr),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (tmr_expire)
   );

   // fwd means heading towards stop; the triangle return leg heads towards start.
   always_comb begin
      tgt_cur  = fwd_q ? stop_q : start_q;
      at_end   = (cur_q == tgt_cur) || (step_q == '0);
      next_fwd = (at_end && mode_q == MODE_TRI) ? ~fwd_q : fwd_q;
      tgt_next = next_fwd ? stop_q : start_q;
      step_up  = next_fwd ? up_q : ~up_q;
      sum_w    = {1'b0, cur_q} + {1'b0, step_q};
      diff_w   = {1'b0, cur_q} - {1'b0, step_q};
      if (step_up)
         stepped = (sum_w[PINC_W] || sum_w[PINC_W-1:0] > tgt_next) ? tgt_next : sum_w[PINC_W-1:0];
      else
         stepped = (diff_w[PINC_W] || diff_w[PINC_W-1:0] < tgt_next) ? tgt_next : diff_w[PINC_W-1:0];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start && !abort) state_d = ST_RUN;
         ST_RUN: begin
            if (abort)
               state_d = ST_IDLE;
            else if (tmr_expire && at_end && mode_q == MODE_SINGLE)
               state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mode_d   = mode_q;
      start_d  = start_q;
      stop_d   = stop_q;
      step_d   = step_q;
      dwell_d  = dwell_q;
      up_d     = up_q;
      fwd_d    = fwd_q;
      cur_d    = cur_q;
      tmr_load = 1'b0;
      tmr_clr  = 1'b0;
      tmr_val  = dwell_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               mode_d   = decode_mode(cfg_mode);
               start_d  = cfg_start;
               stop_d   = cfg_stop;
               step_d   = cfg_step;
               dwell_d  = cfg_dwell;
               up_d     = (cfg_stop >= cfg_start);
               fwd_d    = 1'b1;
               cur_d    = cfg_start;
               tmr_load = 1'b1;
               tmr_val  = cfg_dwell;
            end
         end
         ST_RUN: begin
            if (abort)
               tmr_clr = 1'b1;
            else if (tmr_expire) begin
               if (at_end && mode_q == MODE_SINGLE)
                  tmr_clr = 1'b1;
               else begin
                  cur_d    = (at_end && mode_q == MODE_CONT) ? start_q : stepped;
                  fwd_d    = next_fwd;
                  tmr_load = 1'b1;
               end
            end
         end
         default: tmr_clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_SINGLE;
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         dwell_q <= '0;
         up_q    <= 1'b0;
         fwd_q   <= 1'b0;
         cur_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         step_q  <= step_d;
         dwell_q <= dwell_d;
         up_q    <= up_d;
         fwd_q   <= fwd_d;
         cur_q   <= cur_d;
      end
   end

   always_comb begin
      nco_in_valid = (state_q == ST_RUN);
      nco_in_data  = nco_in_valid ? cur_q : '0;
      busy         = (state_q != ST_IDLE);
      done         = (state_q == ST_DONE);
   end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed and randomized sweeps checked cycle-by-cycle against a point-list model.
module tb_nco_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [1:0]  cfg_mode;
   logic [31:0] cfg_start, cfg_stop, cfg_step;
   logic [15:0] cfg_dwell;
   logic        nco_in_valid, busy, done;
   logic [31:0] nco_in_data;

   int n_checks = 0;
   int n_err    = 0;
   longint pts[$];
   longint fwd_pts[$];
   longint bwd_pts[$];

   nco_sweep_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .cfg_mode     (cfg_mode),
      .cfg_start    (cfg_start),
      .cfg_stop     (cfg_stop),
      .cfg_step     (cfg_step),
      .cfg_dwell    (cfg_dwell),
      .nco_in_valid (nco_in_valid),
      .nco_in_data  (nco_in_data),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Points visited going from a to b, each step clamped at b.
   task automatic walk(input longint a, input longint b, input longint st, input bit to_bwd);
      longint p;
      longint q[$];
      p = a;
      q.push_back(p);
      if (st != 0) begin
         while (p != b) begin
            if (b >= a) p = (p + st > b) ? b : p + st;
            else        p = (p - st < b) ? b : p - st;
            q.push_back(p);
         end
      end
      if (to_bwd) bwd_pts = q;
      else        fwd_pts = q;
   endtask

   // One period of the output point sequence for the given mode.
   task automatic build_pts(input int mode, input longint s, input longint e, input longint st);
      walk(s, e, st, 1'b0);
      walk(e, s, st, 1'b1);
      pts = fwd_pts;
      if (mode == 2) begin
         for (int i = 1; i < bwd_pts.size() - 1; i++)
            pts.push_back(bwd_pts[i]);
      end
   endtask

   task automatic run_case(input string name, input int mode, input longint s, input longint e,
                           input longint st, input int dw, input int n_run, input bit poke);
      int d, len, total;
      bit single;
      build_pts(mode, s, e, st);
      d      = (dw == 0) ? 1 : dw;
      len    = pts.size();
      single = (mode == 0 || mode == 3);
      total  = single ? len * d : n_run;
      cfg_mode  = 2'(mode);
      cfg_start = s[31:0];
      cfg_stop  = e[31:0];
      cfg_step  = st[31:0];
      cfg_dwell = 16'(dw);
      start = 1'b1;
      tick();
      start     = 1'b0;
      cfg_start = $urandom;
      cfg_stop  = $urandom;
      cfg_step  = $urandom;
      cfg_dwell = 16'($urandom);
      cfg_mode  = 2'($urandom);
      for (int k = 0; k < total; k++) begin
         chk({name, ":valid"}, 64'(nco_in_valid), 64'd1);
         chk({name, ":data"},  64'(nco_in_data),  pts[(k / d) % len]);
         chk({name, ":busy"},  64'(busy),         64'd1);
         chk({name, ":done"},  64'(done),         64'd0);
         if (poke && k == 1) start = 1'b1;
         if (!single && k == total - 1) abort = 1'b1;
         tick();
         start = 1'b0;
         abort = 1'b0;
      end
      if (single) begin
         chk({name, ":done_pulse"}, 64'(done),         64'd1);
         chk({name, ":done_valid"}, 64'(nco_in_valid), 64'd0);
         chk({name, ":done_data"},  64'(nco_in_data),  64'd0);
         chk({name, ":done_busy"},  64'(busy),         64'd1);
         tick();
      end
      chk({name, ":idle_valid"}, 64'(nco_in_valid), 64'd0);
      chk({name, ":idle_data"},  64'(nco_in_data),  64'd0);
      chk({name, ":idle_busy"},  64'(busy),         64'd0);
      chk({name, ":idle_done"},  64'(done),         64'd0);
      $display("case %s mode=%0d start=%0d stop=%0d step=%0d dwell=%0d points=%0d cycles=%0d",
               name, mode, s, e, st, dw, len, total);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int m, dw, d;
      longint s, e, st;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_mode = '0; cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0;
      tick();
      tick();
      chk("reset:valid", 64'(nco_in_valid), 64'd0);
      chk("reset:data",  64'(nco_in_data),  64'd0);
      chk("reset:busy",  64'(busy),         64'd0);
      chk("reset:done",  64'(done),         64'd0);
      rst = 1'b0;
      tick();

      run_case("single_up",    0, 100, 130, 10, 3, 0, 1'b0);
      run_case("overshoot",    0, 0, 25, 10, 1, 0, 1'b0);
      run_case("triangle",     2, 10, 30, 10, 1, 14, 1'b0);
      run_case("down_wrap",    0, 5, 0, 8, 2, 0, 1'b0);
      run_case("abort_expiry", 1, 0, 40, 10, 3, 21, 1'b0);
      run_case("start_in_run", 0, 50, 20, 7, 2, 0, 1'b1);
      run_case("dwell0_cont",  1, 0, 9, 3, 0, 11, 1'b0);
      run_case("step0_cont",   1, 77, 500, 0, 2, 40, 1'b0);
      run_case("step0_single", 0, 77, 500, 0, 3, 0, 1'b0);
      run_case("rsvd_mode",    3, 3, 17, 5, 1, 0, 1'b0);
      run_case("top_clamp",    0, 64'hFFFF_FF00, 64'hFFFF_FFFF, 64'h60, 1, 0, 1'b0);
      run_case("tri_down",     2, 40, 10, 15, 1, 12, 1'b0);
      run_case("tri_flat",     2, 9, 9, 4, 2, 8, 1'b0);

      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle:busy", 64'(busy), 64'd0);
      start = 1'b1; abort = 1'b1;
      cfg_mode = 2'd1; cfg_start = 32'd5; cfg_stop = 32'd50; cfg_step = 32'd5; cfg_dwell = 16'd1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("start_abort:busy",  64'(busy),         64'd0);
      chk("start_abort:valid", 64'(nco_in_valid), 64'd0);
      $display("case start_abort_same_cycle busy=%0d", busy);

      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("rst_mid:pre_valid", 64'(nco_in_valid), 64'd1);
      chk("rst_mid:pre_data",  64'(nco_in_data),  64'd15);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid:valid", 64'(nco_in_valid), 64'd0);
      chk("rst_mid:data",  64'(nco_in_data),  64'd0);
      chk("rst_mid:busy",  64'(busy),         64'd0);
      chk("rst_mid:done",  64'(done),         64'd0);
      $display("case rst_mid_sweep valid=%0d busy=%0d", nco_in_valid, busy);
      tick();

      for (int r = 0; r < 8; r++) begin
         m  = $urandom_range(0, 3);
         s  = longint'($urandom_range(0, 300));
         e  = longint'($urandom_range(0, 300));
         st = longint'($urandom_range(1, 60));
         dw = $urandom_range(0, 4);
         d  = (dw == 0) ? 1 : dw;
         run_case($sformatf("rand%0d", r), m, s, e, st, dw, d * $urandom_range(3, 20), 1'b0);
      end
      for (int r = 0; r < 4; r++) begin
         m  = $urandom_range(0, 2);
         s  = longint'(32'hFFFF_FFFF - $urandom_range(0, 200));
         e  = longint'(32'hFFFF_FFFF - $urandom_range(0, 200));
         st = longint'($urandom_range(1, 90));
         run_case($sformatf("rand_top%0d", r), m, s, e, st, 1, 17, 1'b0);
         s  = longint'($urandom_range(0, 150));
         run_case($sformatf("rand_low%0d", r), m, s, 0, st + 100, 2, 10, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
